// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_allocator_pkg;

  localparam int unsigned NOTE_W      = 3;
  localparam int unsigned NNOTES      = 8;
  localparam int unsigned AGE_W       = 4;
  localparam int unsigned INC_W       = 21;

  // Phase accumulator format used to derive the increments.
  localparam int unsigned BITDEPTH    = 14;
  localparam int unsigned BITFRACTION = 6;
  localparam int unsigned SAMPLEFREQ  = 31250;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic              gate;
    logic [NOTE_W-1:0] note;
    logic [AGE_W-1:0]  age;
  } voice_rec_t;

  // Phase increment for a tone given in centi-Hz, truncated.
  function automatic logic [INC_W-1:0] calc_increment(input longint centihz);
    longint num;
    longint den;
    num = centihz * (longint'(1) << (BITDEPTH + BITFRACTION));
    den = longint'(SAMPLEFREQ) * 100;
    return INC_W'(num / den);
  endfunction

  // C5 D5 E5 F5 G5 A5 B5 C6
  localparam logic [INC_W-1:0] INCR_TABLE [NNOTES] = '{
    calc_increment(52325), calc_increment(58733),
    calc_increment(65925), calc_increment(69846),
    calc_increment(78399), calc_increment(88000),
    calc_increment(98776), calc_increment(104650)
  };

endpackage

// File: rtl/voice_select_scan.sv
// Sequential target finder: looks at one voice per SCAN cycle and keeps the
// best retrigger / free / oldest candidates seen so far.
module voice_select_scan
  import voice_allocator_pkg::*;
#(
  parameter int unsigned IDXW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [IDXW-1:0]   idx_i,
  input  logic              gate_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [AGE_W-1:0]  age_i,
  input  logic [NOTE_W-1:0] ev_note_i,
  output logic [IDXW-1:0]   target_o,
  output logic              hit_o
);

  logic            match_found_q, match_found_d;
  logic [IDXW-1:0] match_idx_q, match_idx_d;
  logic            free_found_q, free_found_d;
  logic [IDXW-1:0] free_idx_q, free_idx_d;
  logic            old_found_q, old_found_d;
  logic [IDXW-1:0] old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;
  logic [IDXW-1:0] target_q, target_d;
  logic            hit_q, hit_d;

  // Candidate update; strict '>' keeps the lowest index on age ties.
  always_comb begin
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    if (start_i) begin
      match_found_d = 1'b0;
      match_idx_d   = '0;
      free_found_d  = 1'b0;
      free_idx_d    = '0;
      old_found_d   = 1'b0;
      old_idx_d     = '0;
      old_age_d     = '0;
    end else if (step_i) begin
      if (gate_i && (note_i == ev_note_i) && !match_found_q) begin
        match_found_d = 1'b1;
        match_idx_d   = idx_i;
      end
      if (!gate_i && !free_found_q) begin
        free_found_d = 1'b1;
        free_idx_d   = idx_i;
      end
      if (gate_i && (!old_found_q || (age_i > old_age_q))) begin
        old_found_d = 1'b1;
        old_idx_d   = idx_i;
        old_age_d   = age_i;
      end
    end
    if (match_found_d)     target_d = match_idx_d;
    else if (free_found_d) target_d = free_idx_d;
    else                   target_d = old_idx_d;
    hit_d = match_found_d | free_found_d | old_found_d;
  end

  // Candidate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      target_q      <= '0;
      hit_q         <= 1'b0;
    end else begin
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      target_q      <= target_d;
      hit_q         <= hit_d;
    end
  end

  assign target_o = target_q;
  assign hit_o    = hit_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: accepts note events, picks a voice by scanning
// the bank, commits, and republishes voice state on each sample tick.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NVOICES = 4,
  parameter int unsigned INCW    = 21,
  parameter int unsigned AGEW    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_tick_i,
  input  logic                      ev_valid_i,
  output logic                      ev_ready_o,
  input  logic                      ev_on_i,
  input  logic [2:0]                ev_note_i,
  output logic [NVOICES*INCW-1:0]   voice_incr_o,
  output logic [NVOICES-1:0]        voice_gate_o,
  output logic [NVOICES*3-1:0]      voice_note_o,
  output logic [NVOICES-1:0]        active_mask_o
);

  localparam int unsigned IDXW    = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  // The stored age field is AGE_W wide; AGEW sets the saturation point.
  localparam int unsigned AGE_MAX = (1 << AGEW) - 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   scan_idx_q, scan_idx_d;
  logic              ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic              ev_ready_q, ev_ready_d;
  logic              accept_c, step_c, commit_c;

  voice_rec_t        voices_q [NVOICES];
  voice_rec_t        voices_d [NVOICES];
  logic [INCW-1:0]   incr_q   [NVOICES];
  logic [INCW-1:0]   incr_d   [NVOICES];

  logic [NVOICES*INCW-1:0] voice_incr_q;
  logic [NVOICES-1:0]      voice_gate_q;
  logic [NVOICES*3-1:0]    voice_note_q;

  voice_rec_t        scan_rec_c;
  logic [IDXW-1:0]   target_idx;
  logic              target_hit;

  assign scan_rec_c = voices_q[scan_idx_q];

  voice_select_scan #(
    .IDXW (IDXW)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept_c),
    .step_i    (step_c),
    .idx_i     (scan_idx_q),
    .gate_i    (scan_rec_c.gate),
    .note_i    (scan_rec_c.note),
    .age_i     (scan_rec_c.age),
    .ev_note_i (ev_note_q),
    .target_o  (target_idx),
    .hit_o     (target_hit)
  );

  // Event FSM: accept in IDLE, one voice per SCAN cycle, then COMMIT.
  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    ev_on_d    = ev_on_q;
    ev_note_d  = ev_note_q;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    commit_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_valid_i && ev_ready_q) begin
          accept_c   = 1'b1;
          ev_on_d    = ev_on_i;
          ev_note_d  = ev_note_i;
          scan_idx_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        step_c = 1'b1;
        if (scan_idx_q == IDXW'(NVOICES - 1)) state_d = ST_COMMIT;
        else                                  scan_idx_d = scan_idx_q + 1'b1;
      end
      ST_COMMIT: begin
        commit_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ev_ready_d = (state_d == ST_IDLE);
  end

  // FSM and event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      scan_idx_q <= '0;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      ev_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      ev_on_q    <= ev_on_d;
      ev_note_q  <= ev_note_d;
      ev_ready_q <= ev_ready_d;
    end
  end

  // Working-register update at COMMIT.
  always_comb begin
    voices_d = voices_q;
    incr_d   = incr_q;
    if (commit_c) begin
      for (int i = 0; i < int'(NVOICES); i++) begin
        if (ev_on_q) begin
          if (target_hit && (target_idx == IDXW'(i))) begin
            voices_d[i].gate = 1'b1;
            voices_d[i].note = ev_note_q;
            voices_d[i].age  = '0;
            incr_d[i]        = INCW'(INCR_TABLE[ev_note_q]);
          end else if (voices_q[i].gate && (voices_q[i].age != AGE_W'(AGE_MAX))) begin
            voices_d[i].age = voices_q[i].age + 1'b1;
          end
        end else if (voices_q[i].gate && (voices_q[i].note == ev_note_q)) begin
          voices_d[i].gate = 1'b0;
        end
      end
    end
  end

  // Working registers plus tick-aligned output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NVOICES); i++) begin
        voices_q[i] <= '0;
        incr_q[i]   <= '0;
      end
      voice_incr_q <= '0;
      voice_gate_q <= '0;
      voice_note_q <= '0;
    end else begin
      for (int i = 0; i < int'(NVOICES); i++) begin
        voices_q[i] <= voices_d[i];
        incr_q[i]   <= incr_d[i];
      end
      if (sample_tick_i) begin
        for (int i = 0; i < int'(NVOICES); i++) begin
          voice_incr_q[i*INCW +: INCW] <= incr_q[i];
          voice_gate_q[i]              <= voices_q[i].gate;
          voice_note_q[i*3 +: 3]       <= voices_q[i].note;
        end
      end
    end
  end

  // Live gate state for LEDs/debug.
  always_comb begin
    active_mask_o = '0;
    for (int i = 0; i < int'(NVOICES); i++) active_mask_o[i] = voices_q[i].gate;
  end

  assign ev_ready_o   = ev_ready_q;
  assign voice_incr_o = voice_incr_q;
  assign voice_gate_o = voice_gate_q;
  assign voice_note_o = voice_note_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: event table plus corner sequences.
module tb_voice_allocator;

  localparam int NV   = 4;
  localparam int INCW = 21;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sample_tick;
  logic                 ev_valid;
  logic                 ev_ready;
  logic                 ev_on;
  logic [2:0]           ev_note;
  logic [NV*INCW-1:0]   voice_incr;
  logic [NV-1:0]        voice_gate;
  logic [NV*3-1:0]      voice_note;
  logic [NV-1:0]        active_mask;

  int errors = 0;
  int checks = 0;
  int incr_tab [8] = '{17557, 19707, 22120, 23436, 26306, 29527, 33143, 35114};

  always #5 clk = ~clk;

  voice_allocator #(.NVOICES(NV), .INCW(INCW), .AGEW(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick_i (sample_tick),
    .ev_valid_i    (ev_valid),
    .ev_ready_o    (ev_ready),
    .ev_on_i       (ev_on),
    .ev_note_i     (ev_note),
    .voice_incr_o  (voice_incr),
    .voice_gate_o  (voice_gate),
    .voice_note_o  (voice_note),
    .active_mask_o (active_mask)
  );

  typedef struct {
    logic             on;
    logic [2:0]       note;
    logic [NV-1:0]    gate;
    logic [NV*3-1:0]  notes;
    logic [NV*INCW-1:0] incr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected record; voices absent from 'assigned' have never held a note.
  function automatic vec_t mk(input logic on, input logic [2:0] note, input logic [3:0] gate,
                              input int n3, input int n2, input int n1, input int n0,
                              input logic [3:0] assigned);
    vec_t v;
    int   n [4];
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    v.on = on; v.note = note; v.gate = gate; v.notes = '0; v.incr = '0;
    for (int i = 0; i < 4; i++) begin
      if (assigned[i]) begin
        v.notes[i*3 +: 3]       = 3'(n[i]);
        v.incr[i*INCW +: INCW]  = INCW'(incr_tab[n[i]]);
      end
    end
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (ev_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ev_ready, 1'b1);
  endtask

  // Presents one event, returns the number of sampled cycles ready stayed low.
  task automatic send(input logic on, input logic [2:0] note, output int low);
    wait_ready();
    ev_valid = 1'b1; ev_on = on; ev_note = note;
    @(negedge clk);
    ev_valid = 1'b0;
    low = 0;
    while (ev_ready !== 1'b1 && low < 50) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic tick();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    rst_n = 1'b0; sample_tick = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0;

    vecs[0]  = mk(1'b1, 3'd5, 4'b0001, 0, 0, 0, 5, 4'b0001);
    vecs[1]  = mk(1'b1, 3'd2, 4'b0011, 0, 0, 2, 5, 4'b0011);
    vecs[2]  = mk(1'b1, 3'd2, 4'b0011, 0, 0, 2, 5, 4'b0011);
    vecs[3]  = mk(1'b0, 3'd2, 4'b0001, 0, 0, 2, 5, 4'b0011);
    vecs[4]  = mk(1'b0, 3'd7, 4'b0001, 0, 0, 2, 5, 4'b0011);
    vecs[5]  = mk(1'b1, 3'd1, 4'b0011, 0, 0, 1, 5, 4'b0011);
    vecs[6]  = mk(1'b1, 3'd3, 4'b0111, 0, 3, 1, 5, 4'b0111);
    vecs[7]  = mk(1'b1, 3'd4, 4'b1111, 4, 3, 1, 5, 4'b1111);
    vecs[8]  = mk(1'b1, 3'd6, 4'b1111, 4, 3, 1, 6, 4'b1111);
    vecs[9]  = mk(1'b1, 3'd7, 4'b1111, 4, 3, 7, 6, 4'b1111);
    vecs[10] = mk(1'b0, 3'd6, 4'b1110, 4, 3, 7, 6, 4'b1111);
    vecs[11] = mk(1'b1, 3'd0, 4'b1111, 4, 3, 7, 0, 4'b1111);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ev_ready, 1'b0);
    chk("rst_gate", voice_gate, '0);
    chk("rst_mask", active_mask, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", ev_ready, 1'b1);
    tick();
    chk("rst_tick_gate", voice_gate, '0);
    chk("rst_tick_note", voice_note, '0);
    chk("rst_tick_incr", voice_incr, '0);

    // Event table
    for (int k = 0; k < 12; k++) begin
      send(vecs[k].on, vecs[k].note, low);
      chk($sformatf("v%0d_busy_cycles", k), low, NV + 1);
      tick();
      chk($sformatf("v%0d_gate", k), voice_gate, vecs[k].gate);
      chk($sformatf("v%0d_note", k), voice_note, vecs[k].notes);
      chk($sformatf("v%0d_incr", k), voice_incr, vecs[k].incr);
      chk($sformatf("v%0d_mask", k), active_mask, vecs[k].gate);
    end

    // Tick coincident with the COMMIT edge publishes pre-commit state
    wait_ready();
    ev_valid = 1'b1; ev_on = 1'b0; ev_note = 3'd4;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (NV) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("ct_ready", ev_ready, 1'b1);
    chk("ct_gate_old", voice_gate, 4'b1111);
    chk("ct_mask_new", active_mask, 4'b0111);
    tick();
    chk("ct_gate_new", voice_gate, 4'b0111);
    chk("ct_incr_kept", voice_incr, vecs[11].incr);

    // Reset in the middle of SCAN aborts with no commit
    wait_ready();
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 3'd6;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ev_ready, 1'b0);
    chk("mid_rst_gate", voice_gate, '0);
    chk("mid_rst_incr", voice_incr, '0);
    chk("mid_rst_mask", active_mask, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NV + 3) @(negedge clk);
    chk("mid_rst_idle", ev_ready, 1'b1);
    chk("mid_rst_no_commit", active_mask, '0);
    tick();
    chk("mid_rst_tick_gate", voice_gate, '0);
    chk("mid_rst_tick_note", voice_note, '0);

    // Age saturation: oldest two voices both pin at 15, lowest index is stolen
    for (int n = 0; n < 4; n++) send(1'b1, 3'(n), low);
    for (int r = 0; r < 13; r++) send(1'b1, 3'd3, low);
    send(1'b1, 3'd5, low);
    chk("sat_busy_cycles", low, NV + 1);
    tick();
    chk("sat_gate", voice_gate, 4'b1111);
    chk("sat_note", voice_note, {3'd3, 3'd2, 3'd1, 3'd5});
    chk("sat_incr_v0", voice_incr[0 +: INCW], INCW'(29527));
    chk("sat_incr_v1", voice_incr[INCW +: INCW], INCW'(19707));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
